// File: rtl/main_mem_pkg.sv
// main_mem_pkg
//   Shared types and constants for the block-granular main-memory responder:
//   FSM state encoding, latency counter type, line type and the helper that
//   derives the block-index LSB from the word-offset width.
package main_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // LATENCY is bounded to 1..255, so an 8-bit down-counter suffices.
   localparam int CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam int LINE_W = 512;
   typedef logic [LINE_W-1:0] line_t;

   // Block index starts above the word offset plus the 2 byte-in-word bits.
   function automatic int addr_lsb(input int block_offset);
      return block_offset + 2;
   endfunction

   localparam int DEF_BLOCK_OFFSET = 4;
   localparam int ADDR_LSB         = addr_lsb(DEF_BLOCK_OFFSET);

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array
//   Single-port synchronous line RAM, DATA_W x 2**ADDR_W, with registered
//   read. The read register holds its value until the next read access.
// Ports:
//   clk    in  : clock, rising edge
//   rst    in  : synchronous active-high reset (clears read register only)
//   en     in  : access enable
//   we     in  : 1 = write wdata, 0 = read into rdata
//   addr   in  : line index
//   wdata  in  : write line
//   rdata  out : registered read line
module main_mem_array #(
   parameter int DATA_W = 512,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Storage itself is not reset.
   always_ff @(posedge clk) begin
      if (en && we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)             rdata <= '0;
      else if (en && !we)  rdata <= mem[addr];
   end

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Block-granular main-memory model on the far side of the cache
//   controller's mem_req_* interface. One request at a time; each is serviced
//   LATENCY cycles after acceptance and completed with a one-cycle
//   mem_req_ready pulse. Reads return the whole line on mem_req_datain, which
//   then holds until the next read response.
// Optional build macro:
//   MAIN_MEM_ADDR_CHECK_EN - adds mem_req_error; a request with any address
//   bit set above the index field writes nothing / reads zero, and flags
//   error alongside ready. Without it, upper bits alias modulo depth.
// Ports:
//   clk             in  : clock, rising edge
//   rst             in  : synchronous active-high reset
//   mem_req_enable  in  : request valid
//   mem_req_rw      in  : 1 = write line, 0 = read line
//   mem_req_addr    in  : byte address
//   mem_req_dataout in  : write line from controller
//   mem_req_datain  out : read line to controller
//   mem_req_ready   out : one-cycle completion pulse
//   mem_req_error   out : address-range error (MAIN_MEM_ADDR_CHECK_EN only)
module main_memory_responder
   import main_mem_pkg::*;
#(
   parameter int WORD_SIZE        = 32,
   parameter int BLOCK_OFFSET     = 4,
   parameter int BLOCK_DATA_WIDTH = 512,
   parameter int MEM_INDEX_BITS   = 10,
   parameter int LATENCY          = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_req_enable,
   input  logic                        mem_req_rw,
   input  logic [WORD_SIZE-1:0]        mem_req_addr,
   input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
   output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
   output logic                        mem_req_ready
`ifdef MAIN_MEM_ADDR_CHECK_EN
   ,
   output logic                        mem_req_error
`endif
);

   localparam int   LSB      = addr_lsb(BLOCK_OFFSET);
   localparam int   HI_LSB   = LSB + MEM_INDEX_BITS;
   localparam cnt_t CNT_LOAD = cnt_t'(LATENCY - 1);

   state_t                      state, state_nxt;
   cnt_t                        count;
   logic                        armed;
   logic [MEM_INDEX_BITS-1:0]   idx_q;
   logic                        rw_q;
   logic [BLOCK_DATA_WIDTH-1:0] data_q;
   logic                        accept, commit;
   logic                        err_gate;
   logic                        ram_en, ram_we;
   logic [BLOCK_DATA_WIDTH-1:0] ram_rdata;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      commit        = 1'b0;
      mem_req_ready = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req_enable && armed) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (count == '0) begin
               commit    = 1'b1;
               state_nxt = RESPOND;
            end
         end
         RESPOND: begin
            mem_req_ready = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- counter / re-arm ----------------
   // armed blocks re-acceptance of a request whose enable stays high across
   // ready; any cycle with enable low re-arms.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         armed <= 1'b1;
      end else begin
         if (!mem_req_enable) armed <= 1'b0 | 1'b1;
         else if (accept)     armed <= 1'b0;

         if (accept)                              count <= CNT_LOAD;
         else if (state == BUSY && count != '0)   count <= count - 1'b1;
      end
   end

   // Request latch; inputs are ignored once the request is accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q  <= mem_req_addr[LSB +: MEM_INDEX_BITS];
         rw_q   <= mem_req_rw;
         data_q <= mem_req_dataout;
      end
   end

   // ---------------- address check ----------------
`ifdef MAIN_MEM_ADDR_CHECK_EN
   logic err_q;
   logic rd_zero;

   always_ff @(posedge clk) begin
      if (accept) err_q <= |mem_req_addr[WORD_SIZE-1:HI_LSB];
   end

   // Out-of-range read responds with zero; the flag persists with the
   // response until the next read completes.
   always_ff @(posedge clk) begin
      if (rst)                  rd_zero <= 1'b0;
      else if (commit && !rw_q) rd_zero <= err_q;
   end

   assign err_gate       = err_q;
   assign mem_req_error  = (state == RESPOND) && err_q;
   assign mem_req_datain = rd_zero ? '0 : ram_rdata;

   logic unused_addr_lo;
   assign unused_addr_lo = ^mem_req_addr[LSB-1:0];
`else
   assign err_gate       = 1'b0;
   assign mem_req_datain = ram_rdata;

   // Upper bits alias modulo depth; byte/word offset is irrelevant.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_req_addr[LSB-1:0],
                               mem_req_addr[WORD_SIZE-1:HI_LSB]};
`endif

   // ---------------- array access ----------------
   // Reset on the commit edge wins: no write, no read update.
   assign ram_en = commit && !rst && !err_gate;
   assign ram_we = ram_en && rw_q;

   main_mem_array #(
      .DATA_W (BLOCK_DATA_WIDTH),
      .ADDR_W (MEM_INDEX_BITS)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (idx_q),
      .wdata (data_q),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder
//   Scoreboard bench for main_memory_responder: each accepted request pushes
//   its expected completion cycle, data and error flag; a negedge monitor pops
//   and compares on every ready pulse. Scenario tasks add inline checks.
module tb_main_memory_responder;
   import main_mem_pkg::*;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_enable = 1'b0;
   logic        mem_req_rw = 1'b0;
   logic [31:0] mem_req_addr = '0;
   line_t       mem_req_dataout = '0;
   line_t       mem_req_datain;
   logic        mem_req_ready;
`ifdef MAIN_MEM_ADDR_CHECK_EN
   logic        mem_req_error;
`endif

   main_memory_responder #(.LATENCY(L)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_req_enable  (mem_req_enable),
      .mem_req_rw      (mem_req_rw),
      .mem_req_addr    (mem_req_addr),
      .mem_req_dataout (mem_req_dataout),
      .mem_req_datain  (mem_req_datain),
      .mem_req_ready   (mem_req_ready)
`ifdef MAIN_MEM_ADDR_CHECK_EN
      ,
      .mem_req_error   (mem_req_error)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      line_t data;
      int    cyc;
      bit    err;
   } exp_t;

   exp_t  q[$];
   line_t model[int];
   line_t last_rd = '0;
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   int    rdy_cnt = 0;
   exp_t  me;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mem_req_ready) begin
         rdy_cnt++;
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ready cycle=%0d got ready=1 want 0", cyc);
         end else begin
            me = q.pop_front();
            if (cyc !== me.cyc) begin
               failures++;
               $display("FAIL ready_cycle got %0d want %0d", cyc, me.cyc);
            end
            checks++;
            if (mem_req_datain !== me.data) begin
               failures++;
               $display("FAIL resp_data got %h want %h", mem_req_datain, me.data);
            end
`ifdef MAIN_MEM_ADDR_CHECK_EN
            checks++;
            if (mem_req_error !== me.err) begin
               failures++;
               $display("FAIL resp_error got %b want %b", mem_req_error, me.err);
            end
`endif
         end
      end
`ifdef MAIN_MEM_ADDR_CHECK_EN
      if (mem_req_error && !mem_req_ready) begin
         checks++;
         failures++;
         $display("FAIL error_without_ready cycle=%0d", cyc);
      end
`endif
   end

   // Drive one request and return just after its acceptance edge; enable is
   // left high. track=0 means the request is expected to be aborted.
   task automatic issue(input bit rw, input logic [31:0] addr, input line_t wdata,
                        input bit track);
      exp_t e;
      int   idx;
      bit   err;
      idx = int'(addr[15:6]);
      err = 1'b0;
`ifdef MAIN_MEM_ADDR_CHECK_EN
      err = |addr[31:16];
`endif
      @(negedge clk);
      mem_req_enable  = 1'b1;
      mem_req_rw      = rw;
      mem_req_addr    = addr;
      mem_req_dataout = wdata;
      @(posedge clk);
      #1;
      if (track) begin
         if (rw) begin
            if (!err) model[idx] = wdata;
            e.data = last_rd;
         end else begin
            e.data  = err ? '0 : (model.exists(idx) ? model[idx] : '0);
            last_rd = e.data;
         end
         e.cyc = cyc + L;
         e.err = err;
         q.push_back(e);
      end
   endtask

   // Drop enable and wait (bounded) for the scoreboard to drain.
   task automatic finish_req();
      mem_req_enable = 1'b0;
      for (int i = 0; i < L + 10 && q.size() != 0; i++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL response_timeout got pending=%0d want 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_req(input bit rw, input logic [31:0] addr, input line_t wdata);
      issue(rw, addr, wdata, 1'b1);
      finish_req();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0;
      checks++;
      if (mem_req_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got %b want 0", mem_req_ready);
      end
      checks++;
      if (mem_req_datain !== '0) begin
         failures++;
         $display("FAIL reset_datain got %h want 0", mem_req_datain);
      end
`ifdef MAIN_MEM_ADDR_CHECK_EN
      checks++;
      if (mem_req_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_error got %b want 0", mem_req_error);
      end
`endif
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (mem_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready cycle=%0d got 1 want 0", k);
         end
      end
   endtask

   task automatic test_latency();
      // Known contents for lines used later.
      do_req(1'b1, 32'h0000_0040, '0);
      do_req(1'b1, 32'h0000_1000, '0);
      do_req(1'b1, 32'h0000_0000, '0);
      issue(1'b0, 32'h0000_0040, '0, 1'b1);
      for (int k = 0; k <= L; k++) begin
         @(negedge clk);
         checks++;
         if (mem_req_ready !== (k == L)) begin
            failures++;
            $display("FAIL latency_ready k=%0d got %b want %b", k, mem_req_ready, (k == L));
         end
      end
      finish_req();
   endtask

   task automatic test_write_read();
      line_t w;
      for (int i = 0; i < 16; i++) w[32*i +: 32] = 32'hDEADBEEF + i;
      do_req(1'b1, 32'h0000_0ABC, w);
      do_req(1'b0, 32'h0000_0A80, '0);
      checks++;
      if (mem_req_datain[5*32 +: 32] !== 32'hDEADBEF4) begin
         failures++;
         $display("FAIL rd_word5 got %h want deadbef4", mem_req_datain[5*32 +: 32]);
      end
   endtask

   task automatic test_hold_enable();
      int pulses;
      int base;
      base   = rdy_cnt;
      pulses = 0;
      issue(1'b0, 32'h0000_0A80, '0, 1'b1);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (mem_req_ready) pulses++;
      end
      checks++;
      if (pulses !== 1) begin
         failures++;
         $display("FAIL hold_pulses got %0d want 1", pulses);
      end
      mem_req_enable = 1'b0;
      issue(1'b0, 32'h0000_0A80, '0, 1'b1);
      finish_req();
      checks++;
      if (rdy_cnt - base !== 2) begin
         failures++;
         $display("FAIL rearm_pulses got %0d want 2", rdy_cnt - base);
      end
   endtask

   task automatic test_reset_abort();
      line_t w;
      int    seen;
      for (int i = 0; i < 16; i++) w[32*i +: 32] = 32'hFACECAFE;
      issue(1'b1, 32'h0000_1000, w, 1'b0);
      @(negedge clk);
      mem_req_enable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_rd = '0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_req_ready) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_ready got %0d pulses want 0", seen);
      end
      do_req(1'b0, 32'h0000_1000, '0);
   endtask

   task automatic test_upper_addr();
      line_t w;
      for (int i = 0; i < 16; i++) w[32*i +: 32] = 32'h5A5A_0000 + i;
      do_req(1'b1, 32'h0001_0000, w);
      do_req(1'b0, 32'h0000_0000, '0);
      do_req(1'b0, 32'h0001_0A80, '0);
   endtask

   task automatic test_random();
      logic [31:0] addrs [4];
      line_t       w;
      addrs[0] = 32'h0000_0200;
      addrs[1] = 32'h0000_0240;
      addrs[2] = 32'h0000_FFC0;
      addrs[3] = 32'h0000_0204;
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
         do_req(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], w);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_write_read();
      test_hold_enable();
      test_reset_abort();
      test_upper_addr();
      test_random();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
